// File: rtl/pbvi_pkg.sv
// Shared types and constants for the multi-agent POMDP belief-update scheduler.
package pbvi_pkg;

    localparam int unsigned NUM_STATES     = 2;
    localparam int unsigned NUM_ACTIONS    = 3;
    localparam logic [15:0] BELIEF_UNIFORM = 16'h8000;

    typedef logic [1:0] action_t;

    // Two-state belief, Q0.16 per state; b0 occupies the upper half when flattened.
    typedef struct packed {
        logic [15:0] b0;
        logic [15:0] b1;
    } belief_t;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StCommit} sched_state_e;

    function automatic logic action_legal(action_t a);
        return a < action_t'(NUM_ACTIONS);
    endfunction

endpackage

// File: rtl/pbvi_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward (wrapping) from last_grant+1.
module pbvi_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand     = (32'(last_grant) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!grant_any && req[cand_idx]) begin
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
                grant_any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pbvi_belief_sched.sv
// Time-shares one belief-update datapath among NUM_AGENTS agents, holding each agent's
// belief locally and committing datapath results back round-robin.
module pbvi_belief_sched
    import pbvi_pkg::*;
#(
    parameter int unsigned NUM_AGENTS = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_AGENTS-1:0]         req_valid,
    input  logic [NUM_AGENTS-1:0][1:0]    req_action,
    input  logic [NUM_AGENTS-1:0]         req_obs,
    output logic [NUM_AGENTS-1:0]         req_ready,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_AGENTS)-1:0] cfg_agent,
    input  belief_t                       cfg_belief,
    output logic                          cfg_ready,
    output logic                          dp_en,
    output action_t                       dp_action,
    output logic                          dp_obs,
    output belief_t                       dp_belief,
    input  logic                          dp_done,
    input  belief_t                       dp_result,
    output logic                          rsp_valid,
    output logic [$clog2(NUM_AGENTS)-1:0] rsp_agent,
    output belief_t                       rsp_belief,
    output logic                          rsp_err,
    output logic                          busy
);

    localparam int unsigned AW      = $clog2(NUM_AGENTS);
    localparam int unsigned CW      = $clog2(TIMEOUT + 1);
    localparam belief_t     UNIFORM = '{b0: BELIEF_UNIFORM, b1: BELIEF_UNIFORM};

    sched_state_e  state_q;
    logic [AW-1:0] gnt_q;
    logic [AW-1:0] last_grant_q;
    logic [CW-1:0] cnt_q;
    belief_t       bel_q [NUM_AGENTS];

    logic [NUM_AGENTS-1:0] arb_gnt;
    logic [AW-1:0]         arb_idx;
    logic                  arb_any;

    pbvi_rr_arbiter #(
        .NUM_REQ (NUM_AGENTS)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (arb_gnt),
        .grant_idx  (arb_idx),
        .grant_any  (arb_any)
    );

    // dp_en is high during the first WAIT cycle; a strobe seen then belongs to the issue cycle.
    logic wait_done;
    logic wait_expire;
    logic result_ok;

    always_comb begin
        wait_done   = !dp_en && dp_done;
        wait_expire = !dp_en && !dp_done && ((cnt_q + CW'(1)) == CW'(TIMEOUT));
        result_ok   = wait_done && (dp_result != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            gnt_q        <= '0;
            last_grant_q <= AW'(NUM_AGENTS - 1);
            cnt_q        <= '0;
            bel_q        <= '{default: UNIFORM};
            req_ready    <= '0;
            cfg_ready    <= 1'b1;
            dp_en        <= 1'b0;
            dp_action    <= '0;
            dp_obs       <= 1'b0;
            dp_belief    <= '0;
            rsp_valid    <= 1'b0;
            rsp_agent    <= '0;
            rsp_belief   <= '0;
            rsp_err      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            req_ready <= '0;
            dp_en     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            unique case (state_q)
                // COMMIT arbitrates like IDLE so back-to-back grants leave no bubble.
                StIdle, StCommit: begin
                    if (state_q == StIdle && cfg_we) begin
                        if (32'(cfg_agent) < NUM_AGENTS) begin
                            bel_q[cfg_agent] <= cfg_belief;
                        end
                    end else if (arb_any) begin
                        req_ready <= arb_gnt;
                        gnt_q     <= arb_idx;
                        dp_action <= req_action[arb_idx];
                        dp_obs    <= req_obs[arb_idx];
                        dp_belief <= bel_q[arb_idx];
                        state_q   <= StIssue;
                        busy      <= 1'b1;
                        cfg_ready <= 1'b0;
                    end else begin
                        state_q   <= StIdle;
                        busy      <= 1'b0;
                        cfg_ready <= 1'b1;
                    end
                end
                StIssue: begin
                    if (action_legal(dp_action)) begin
                        dp_en   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= StWait;
                    end else begin
                        rsp_valid    <= 1'b1;
                        rsp_err      <= 1'b1;
                        rsp_agent    <= gnt_q;
                        rsp_belief   <= bel_q[gnt_q];
                        last_grant_q <= gnt_q;
                        state_q      <= StCommit;
                    end
                end
                StWait: begin
                    if (wait_done || wait_expire) begin
                        rsp_valid    <= 1'b1;
                        rsp_agent    <= gnt_q;
                        last_grant_q <= gnt_q;
                        state_q      <= StCommit;
                        if (result_ok) begin
                            bel_q[gnt_q] <= dp_result;
                            rsp_belief   <= dp_result;
                        end else begin
                            rsp_belief   <= bel_q[gnt_q];
                            rsp_err      <= 1'b1;
                        end
                    end else if (!dp_en) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pbvi_belief_sched.sv
// Self-checking bench for pbvi_belief_sched: directed vector table, corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_pbvi_belief_sched;
    import pbvi_pkg::*;

    localparam int NA = 4;
    localparam int TO = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NA-1:0]        req_valid;
    logic [NA-1:0][1:0]   req_action;
    logic [NA-1:0]        req_obs;
    logic [NA-1:0]        req_ready;
    logic                 cfg_we;
    logic [1:0]           cfg_agent;
    logic [31:0]          cfg_belief;
    logic                 cfg_ready;
    logic                 dp_en;
    logic [1:0]           dp_action;
    logic                 dp_obs;
    logic [31:0]          dp_belief;
    logic                 dp_done;
    logic [31:0]          dp_result;
    logic                 rsp_valid;
    logic [1:0]           rsp_agent;
    logic [31:0]          rsp_belief;
    logic                 rsp_err;
    logic                 busy;

    pbvi_belief_sched #(
        .NUM_AGENTS (NA),
        .TIMEOUT    (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_action (req_action),
        .req_obs    (req_obs),
        .req_ready  (req_ready),
        .cfg_we     (cfg_we),
        .cfg_agent  (cfg_agent),
        .cfg_belief (cfg_belief),
        .cfg_ready  (cfg_ready),
        .dp_en      (dp_en),
        .dp_action  (dp_action),
        .dp_obs     (dp_obs),
        .dp_belief  (dp_belief),
        .dp_done    (dp_done),
        .dp_result  (dp_result),
        .rsp_valid  (rsp_valid),
        .rsp_agent  (rsp_agent),
        .rsp_belief (rsp_belief),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Datapath model: dp_done arrives dp_delay cycles after the dp_en cycle; 0 means never.
    int          dp_delay = 1;
    logic [31:0] dp_val   = '0;
    int          pend     = 0;

    always @(negedge clk) begin
        dp_done   = 1'b0;
        dp_result = 32'hDEADBEEF;
        if (!rst_n) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend = pend - 1;
                if (pend == 0) begin
                    dp_done   = 1'b1;
                    dp_result = dp_val;
                end
            end
            if (dp_en && dp_delay > 0) pend = dp_delay;
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    typedef struct {
        bit          done;
        int          gcyc;
        int          grant;
        int          lat;
        int          agent;
        logic        err;
        logic [31:0] bel;
        int          dpen;
        logic [31:0] dpb;
        logic [1:0]  dpa;
        logic        dpo;
        logic        busy_en;
        logic        cr_en;
    } res_t;

    task automatic run_txn(input logic [NA-1:0] mask, input logic [NA-1:0][1:0] acts,
                           input logic [NA-1:0] obs, output res_t r);
        r = '{done: 0, gcyc: -1, grant: -1, lat: -1, agent: -1, err: 1'bx, bel: 'x,
              dpen: 0, dpb: 'x, dpa: 'x, dpo: 1'bx, busy_en: 1'bx, cr_en: 1'bx};
        req_valid  = mask;
        req_action = acts;
        req_obs    = obs;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (r.gcyc < 0 && req_ready != '0) begin
                r.gcyc = k;
                r.grant = ($countones(req_ready) == 1) ? -2 : -3;
                for (int i = 0; i < NA; i++) if (req_ready == (NA'(1) << i)) r.grant = i;
                req_valid = '0;
            end
            if (dp_en) begin
                r.dpen++;
                r.dpb     = dp_belief;
                r.dpa     = dp_action;
                r.dpo     = dp_obs;
                r.busy_en = busy;
                r.cr_en   = cfg_ready;
            end
            if (rsp_valid) begin
                r.done  = 1;
                r.lat   = k - r.gcyc;
                r.agent = rsp_agent;
                r.err   = rsp_err;
                r.bel   = rsp_belief;
                break;
            end
        end
        req_valid = '0;
    endtask

    typedef struct {
        int          agent;
        logic [1:0]  act;
        logic        obs;
        int          delay;
        logic [31:0] res;
        logic [31:0] exp_dpb;
        logic        exp_err;
        logic [31:0] exp_bel;
        int          exp_lat;
        int          exp_dpen;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] m_bel [NA];
    int          m_last;

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: got no finish required finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        res_t              r;
        logic [NA-1:0]     mask;
        logic [NA-1:0][1:0] acts;
        logic [NA-1:0]     obs;
        int                g, elat, edpen, seen, nrsp, ca;
        logic              eerr;
        logic [31:0]       edpb, cv;
        int                gidx [5];
        int                gcy  [5];
        int                ng;

        vecs[0] = '{2, 2'd1, 1'b0,  1, 32'h4000C000, 32'h80008000, 1'b0, 32'h4000C000,  3, 1};
        vecs[1] = '{0, 2'd0, 1'b1,  3, 32'h12345678, 32'h80008000, 1'b0, 32'h12345678,  5, 1};
        vecs[2] = '{2, 2'd2, 1'b1,  1, 32'h00000000, 32'h4000C000, 1'b1, 32'h4000C000,  3, 1};
        vecs[3] = '{3, 2'd3, 1'b0,  1, 32'h11112222, 32'h0,        1'b1, 32'h80008000,  1, 0};
        vecs[4] = '{1, 2'd1, 1'b0,  0, 32'h0,        32'h80008000, 1'b1, 32'h80008000, 18, 1};
        vecs[5] = '{2, 2'd0, 1'b0,  2, 32'h0001FFFF, 32'h4000C000, 1'b0, 32'h0001FFFF,  4, 1};
        vecs[6] = '{0, 2'd2, 1'b1, 16, 32'hAAAA5555, 32'h12345678, 1'b0, 32'hAAAA5555, 18, 1};
        vecs[7] = '{0, 2'd1, 1'b0, 17, 32'h12121212, 32'hAAAA5555, 1'b1, 32'hAAAA5555, 18, 1};

        rst_n = 1'b0; req_valid = '0; req_action = '0; req_obs = '0;
        cfg_we = 1'b0; cfg_agent = '0; cfg_belief = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("reset req_ready", req_ready, 0);
        chk("reset dp_en", dp_en, 0);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_err", rsp_err, 0);
        chk("reset busy", busy, 0);
        chk("reset cfg_ready", cfg_ready, 1);
        chk("reset dp_operands", {dp_action, dp_obs, dp_belief}, 0);
        chk("reset rsp_fields", {rsp_agent, rsp_belief}, 0);

        // Directed table, single requester per vector.
        foreach (vecs[i]) begin
            mask = '0; acts = '0; obs = '0;
            mask[vecs[i].agent] = 1'b1;
            acts[vecs[i].agent] = vecs[i].act;
            obs[vecs[i].agent]  = vecs[i].obs;
            dp_delay = vecs[i].delay;
            dp_val   = vecs[i].res;
            run_txn(mask, acts, obs, r);
            chk($sformatf("vec%0d done", i), r.done, 1);
            chk($sformatf("vec%0d grant", i), r.grant, vecs[i].agent);
            chk($sformatf("vec%0d latency", i), r.lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d rsp_agent", i), r.agent, vecs[i].agent);
            chk($sformatf("vec%0d rsp_err", i), r.err, vecs[i].exp_err);
            chk($sformatf("vec%0d rsp_belief", i), r.bel, vecs[i].exp_bel);
            chk($sformatf("vec%0d dp_en count", i), r.dpen, vecs[i].exp_dpen);
            if (vecs[i].exp_dpen != 0) begin
                chk($sformatf("vec%0d dp_belief", i), r.dpb, vecs[i].exp_dpb);
                chk($sformatf("vec%0d dp_action/obs", i), {r.dpa, r.dpo},
                    {vecs[i].act, vecs[i].obs});
                chk($sformatf("vec%0d busy/cfg_ready at dp_en", i), {r.busy_en, r.cr_en}, 2'b10);
            end
        end

        // Reset during WAIT: no response, all entries back to uniform.
        repeat (4) @(negedge clk);
        dp_delay = 0; req_action = '0; req_obs = '0; req_valid = 4'b0001;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_ready != '0) req_valid = '0;
            if (dp_en) begin seen = 1; break; end
        end
        req_valid = '0;
        chk("rst_wait dp_en seen", seen, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        nrsp = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (rsp_valid) nrsp++;
        end
        chk("rst_wait no rsp_valid", nrsp, 0);
        chk("rst_wait cfg_ready", cfg_ready, 1);
        chk("rst_wait busy", busy, 0);
        for (int a = 0; a < NA; a++) begin
            mask = '0; mask[a] = 1'b1; acts = '0; obs = '0;
            dp_delay = 1; dp_val = 32'h1000_2000 + 32'(a);
            run_txn(mask, acts, obs, r);
            chk($sformatf("rst_wait agent%0d grant", a), r.grant, a);
            chk($sformatf("rst_wait agent%0d dp_belief", a), r.dpb, 32'h80008000);
        end

        // All agents requesting continuously.
        dp_delay = 1; dp_val = 32'h33334444;
        req_action = '0; req_obs = '0; req_valid = '1;
        ng = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                gidx[ng] = -1;
                for (int i = 0; i < NA; i++) if (req_ready == (NA'(1) << i)) gidx[ng] = i;
                gcy[ng] = k;
                ng++;
                if (ng == 5) break;
            end
        end
        req_valid = '0;
        chk("rr grant count", ng, 5);
        for (int i = 0; i < ng; i++) begin
            chk($sformatf("rr grant%0d agent", i), gidx[i], i % NA);
            if (i > 0) chk($sformatf("rr grant%0d spacing", i), gcy[i] - gcy[i-1], 4);
        end
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (!busy) begin seen = 1; break; end
        end
        chk("rr drains to idle", seen, 1);
        for (int i = 0; i < NA; i++) m_bel[i] = 32'h33334444;
        m_last = 0;

        // Cfg write collides with a request to the same agent.
        @(negedge clk);
        chk("coll cfg_ready before", cfg_ready, 1);
        cfg_we = 1'b1; cfg_agent = 2'd1; cfg_belief = 32'hFFFF0001;
        req_valid = 4'b0010; req_action = '0; req_obs = '0;
        dp_delay = 1; dp_val = 32'h5555AAAA;
        @(negedge clk);
        cfg_we = 1'b0;
        chk("coll grant deferred", req_ready, 0);
        run_txn(4'b0010, '0, '0, r);
        chk("coll grant cycle", r.gcyc, 1);
        chk("coll grant agent", r.grant, 1);
        chk("coll dp_belief", r.dpb, 32'hFFFF0001);
        chk("coll rsp_belief", r.bel, 32'h5555AAAA);
        m_bel[1] = 32'h5555AAAA;
        m_last = 1;

        // Randomized multi-requester traffic against the transaction model.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                seen = 0;
                for (int k = 0; k < 20; k++) begin
                    if (cfg_ready) begin seen = 1; break; end
                    @(negedge clk);
                end
                chk($sformatf("rnd%0d cfg_ready", t), seen, 1);
                ca = $urandom_range(0, NA - 1);
                cv = $urandom;
                cfg_we = 1'b1; cfg_agent = 2'(ca); cfg_belief = cv;
                @(negedge clk);
                cfg_we = 1'b0;
                m_bel[ca] = cv;
            end
            mask = NA'($urandom_range(1, (1 << NA) - 1));
            for (int i = 0; i < NA; i++) begin
                acts[i] = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                obs[i]  = 1'($urandom_range(0, 1));
            end
            dp_delay = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 5));
            dp_val   = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;

            g = -1;
            for (int i = 1; i <= NA; i++) if (g < 0 && mask[(m_last + i) % NA]) g = (m_last + i) % NA;
            edpb = m_bel[g];
            if (acts[g] == 2'd3) begin
                elat = 1; eerr = 1'b1; edpen = 0;
            end else if (dp_delay == 0) begin
                elat = 2 + TO; eerr = 1'b1; edpen = 1;
            end else begin
                elat = dp_delay + 2; edpen = 1; eerr = (dp_val == 32'h0);
                if (!eerr) m_bel[g] = dp_val;
            end
            m_last = g;

            run_txn(mask, acts, obs, r);
            chk($sformatf("rnd%0d grant", t), r.grant, g);
            chk($sformatf("rnd%0d latency", t), r.lat, elat);
            chk($sformatf("rnd%0d rsp_agent", t), r.agent, g);
            chk($sformatf("rnd%0d rsp_err", t), r.err, eerr);
            chk($sformatf("rnd%0d rsp_belief", t), r.bel, m_bel[g]);
            chk($sformatf("rnd%0d dp_en count", t), r.dpen, edpen);
            if (edpen != 0) begin
                chk($sformatf("rnd%0d dp_operands", t), {r.dpa, r.dpo, r.dpb},
                    {acts[g], obs[g], edpb});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
